// File: rtl/comp_pkg.sv
// Shared FSM encoding and sizing helper for the serial digit comparator.
package comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width; kept at 1 bit even when there is a single digit.
    function automatic int cnt_w(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/comp_digit.sv
// Unsigned magnitude compare of one D-bit digit pair.
module comp_digit #(
    parameter int D = 1
) (
    input  logic [D-1:0] da,
    input  logic [D-1:0] db,
    output logic         dgt,
    output logic         dlt
);

    assign dgt = (da > db);
    assign dlt = (da < db);

endmodule

// File: rtl/comp_serial_n_bit.sv
// Serial MSB-first comparator: one D-bit digit per cycle, stops at the first
// differing digit. Signed mode biases the sign bit so the unsigned walk works.
module comp_serial_n_bit
    import comp_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_signed,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    localparam int NDIG = (D > 0) ? N / D : 1;
    localparam int CW   = cnt_w(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
    localparam logic [N-1:0]  SIGN = N'(1) << (N - 1);

    generate
        if (D < 1 || D > N || (N % D) != 0) begin : g_bad_param
            $error("comp_serial_n_bit: D must satisfy 1 <= D <= N and N %% D == 0");
        end
    endgenerate

    state_t        state;
    logic [N-1:0]  sa, sb;
    logic [CW-1:0] cnt;
    logic          dgt, dlt;

    comp_digit #(.D(D)) u_digit (
        .da  (sa[N-1 -: D]),
        .db  (sb[N-1 -: D]),
        .dgt (dgt),
        .dlt (dlt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa    <= cmp_signed ? (a ^ SIGN) : a;
                        sb    <= cmp_signed ? (b ^ SIGN) : b;
                        cnt   <= '0;
                        gt    <= 1'b0;
                        eq    <= 1'b0;
                        lt    <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (dgt || dlt) begin
                        gt    <= dgt;
                        lt    <= dlt;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (cnt == LAST) begin
                        eq    <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        sa  <= sa << D;
                        sb  <= sb << D;
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_serial_n_bit.sv
// Scoreboard bench: two comparators (D=1 and D=4) share stimulus; expected
// results and done cycles come from plain arithmetic on the operands.
module tb_comp_serial_n_bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cmp_signed = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [1:0] busy, done, gt, eq, lt;

    typedef struct {
        logic [2:0] res;   // {gt, eq, lt}
        int         cyc;
    } exp_t;

    exp_t       q [2][$];
    logic [2:0] last [2];
    int         cyc = 0;
    int         nchk = 0;
    int         nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comp_serial_n_bit #(.N(8), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .cmp_signed(cmp_signed), .a(a), .b(b),
        .busy(busy[0]), .done(done[0]), .gt(gt[0]), .eq(eq[0]), .lt(lt[0])
    );

    comp_serial_n_bit #(.N(8), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .cmp_signed(cmp_signed), .a(a), .b(b),
        .busy(busy[1]), .done(done[1]), .gt(gt[1]), .eq(eq[1]), .lt(lt[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int digw(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Result from integer comparison; done cycle from the first differing bit.
    function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic s, input int d, input int now);
        exp_t       e;
        logic [7:0] x;
        int         p;
        e.res[2] = s ? ($signed(ma) > $signed(mb)) : (ma > mb);
        e.res[1] = (ma == mb);
        e.res[0] = s ? ($signed(ma) < $signed(mb)) : (ma < mb);
        x = ma ^ mb;
        p = -1;
        for (int k = 0; k < 8; k++) if (x[k]) p = k;
        if (p < 0) e.cyc = now + (8 / d - 1) + 2;
        else       e.cyc = now + (7 - p) / d + 2;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic is);
        int t = 0;
        while ((busy != 2'b00 || q[0].size() != 0 || q[1].size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("issue_timeout", 32'(t), 32'd0);
        start = 1'b1; a = ia; b = ib; cmp_signed = is;
        for (int i = 0; i < 2; i++) q[i].push_back(model(ia, ib, is, digw(i), cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                last[i] = 3'b000;
            end else begin
                chk($sformatf("busy_d%0d", digw(i)), 32'(busy[i]), 32'(q[i].size() != 0));
                if (done[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("spurious_done_d%0d", digw(i)), 32'(done[i]), 32'd0);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        chk($sformatf("result_d%0d", digw(i)), 32'({gt[i], eq[i], lt[i]}), 32'(e.res));
                        chk($sformatf("done_cycle_d%0d", digw(i)), 32'(cyc), 32'(e.cyc));
                        last[i] = e.res;
                    end
                end else if (!busy[i]) begin
                    chk($sformatf("hold_d%0d", digw(i)), 32'({gt[i], eq[i], lt[i]}), 32'(last[i]));
                end
            end
        end
    end

    initial begin
        int t;
        logic [7:0] ra, rb;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({busy, done, gt, eq, lt}), 32'd0);
        rst = 1'b0;

        issue(8'h80, 8'h7F, 1'b0);            // gt, early exit on MSB
        issue(8'h5A, 8'h5A, 1'b0);            // eq, full length
        issue(8'h80, 8'h01, 1'b1);            // signed: lt
        issue(8'h80, 8'h01, 1'b0);            // unsigned: gt
        issue(8'h3C, 8'h3D, 1'b0);            // lt on last digit
        issue(8'h7F, 8'h80, 1'b1);            // signed extremes

        // Second start with other operands during cycle 1 must be ignored.
        issue(8'h5A, 8'h5A, 1'b0);
        start = 1'b1; a = 8'h01; b = 8'hFF; cmp_signed = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset in cycle 3 of a full-length compare, then restart immediately.
        issue(8'h5A, 8'h5A, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        q[0].delete();
        q[1].delete();
        #1;
        chk("midrun_reset_outputs", 32'({busy, done, gt, eq, lt}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(8'hC3, 8'h3C, 1'b1);

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            issue(ra, rb, 1'($urandom));
        end

        t = 0;
        while ((busy != 2'b00 || q[0].size() != 0 || q[1].size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("drain_timeout", 32'(t), 32'd0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
